motor_enc_decoder: RTL and testbench
====================================

# motor_enc_decoder

Parametrised successor to the single-channel scan-motor read-head decoder. It takes the raw tooth-wheel feedback signal, locates the physical zero tooth (a long high pulse), and tracks tooth falls within each revolution. It reports real and virtual zero strobes, step index, per-tooth and averaged per-revolution periods, stall, tooth-count error and end-of-region strobes. It sits between the motor feedback pin and the ranging/angle logic. Unlike the previous decoder, tooth count, offsets, thresholds and averaging depth are parameters, and it detects missing or extra teeth.

## Interface
- CNT_W, 32, width of all period/timer counters
- TEETH, 44, tooth falls per revolution including the zero-tooth fall
- VZERO_OFS, 8, track-fall index that raises virtual_zero
- FEED_FIRST, 1, first step_idx with feed_valid high
- FEED_LAST, 42, last step_idx with feed_valid high
- REGION_END, 40, step_idx whose entry pulses region_done
- ZR_SHIFT, 1, zero test is high_cnt > low_cnt + (low_cnt >> ZR_SHIFT)
- STALL_TICKS, 3125000, clk cycles without a rise before stall
- AVE_LOG2, 2, revolution-period average over 2^AVE_LOG2 revolutions
- FILT_LEN, 4, glitch-filter length in clk cycles (macro only)
- clk  in  1  system clock
- rst_n  in  1  reset rst_n, asynchronous, active-low; clock clk
- motor_enable  in  1  motor running request; low forces IDLE and clears tracking
- pulse_sig  in  1  raw asynchronous tooth feedback
- real_zero  out  1  one-cycle strobe when the zero tooth is recognised
- virtual_zero  out  1  one-cycle strobe on track fall number VZERO_OFS
- tooth_fall  out  1  one-cycle strobe on every qualified falling edge
- locked  out  1  high from first real_zero until error/stall/disable
- tooth_err  out  1  one-cycle strobe on tooth-count mismatch
- stall  out  1  level; motor enabled but no rise for STALL_TICKS
- region_done  out  1  one-cycle strobe when step_idx becomes REGION_END
- feed_valid  out  1  level; FEED_FIRST <= track count <= FEED_LAST
- step_idx  out  8  falls since last virtual_zero (wraps via virtual_zero)
- tooth_sub  out  CNT_W  clk cycles since last fall while in TRACK
- tooth_period  out  CNT_W  last full fall-to-fall period in TRACK
- rev_period  out  CNT_W  moving average of zero-to-zero periods
- rev_valid  out  1  one-cycle strobe when rev_period updates

## Operation
- Input: 2-flop synchroniser, then edge detect on the qualified signal q. High_cnt counts while q=1 and low_cnt while q=0. Both clear on a fall and saturate at all-ones.
- States (one-hot): IDLE, PRE1, HUNT, SKIP, TRACK. motor_enable=0 forces IDLE from any state.
- IDLE -> PRE1 on fall. PRE1 -> HUNT on rise. Entering on an edge discards partial counts.
- HUNT -> SKIP when the zero test is true; real_zero fires that cycle. A fall in HUNT without the test true: if locked, pulse tooth_err and clear locked; stay in HUNT.
- SKIP -> TRACK on the fall ending the zero pulse. The track count resets to 0 on entering TRACK.
- TRACK: each fall increments the track count. Reaching TEETH-1 goes to HUNT. stall goes to IDLE and clears locked.
- Zero test true in TRACK before TEETH-1 falls: pulse tooth_err, go to SKIP, raise real_zero, keep locked (resync).
- locked sets on real_zero and clears on tooth_err from HUNT, on stall, and on motor_enable=0.
- step_idx clears on virtual_zero and increments on other tooth_fall while enabled. It holds 0 while disabled and wraps at 255.
- feed_valid uses the track count and is 0 outside TRACK.
- Rev counter resets on real_zero; its value before reset is pushed into a 2^AVE_LOG2-deep shift register with a running sum, and rev_period = sum >> AVE_LOG2. History, sum and rev_period clear when motor_enable=0. rev_valid pulses the cycle after each push. The first push after lock is discarded (partial revolution).
- Stall timer clears on rise and increments saturating at STALL_TICKS while enabled. It is 0 while disabled.

## Timing
- Latency pulse_sig edge -> tooth_fall: 3 clk without filter, 3+FILT_LEN with filter.
- real_zero, virtual_zero, tooth_err and region_done are combinational-free registered strobes, exactly 1 cycle wide.
- tooth_period loads on the fall cycle with the pre-clear tooth_sub value.
- Reset values: all strobes 0, locked 0, stall 0, step_idx 0, tooth_sub 0, tooth_period 0, rev_period 0, state IDLE.
- A fall on the same cycle as a stall assertion: the stall wins.
- motor_enable falling mid-revolution: all outputs return to reset values next cycle except tooth_period, which holds.

## Configuration
- MOTOR_ENC_FILTER_EN defined: q changes only after the synchronised input holds a new level for FILT_LEN consecutive cycles; shorter glitches are ignored.
- Undefined: q equals the synchronised input and FILT_LEN is unused.

## Test plan
- TEETH=8, VZERO_OFS=2. Normal teeth 10 high/10 low, zero tooth 40 high. Expect real_zero once per revolution, virtual_zero on the 2nd track fall, locked=1, no tooth_err.
- Same stimulus with one normal tooth removed. Expect tooth_err pulse in HUNT, locked=0, relock on the next zero.
- Zero tooth injected after 4 track falls. Expect tooth_err plus real_zero the same cycle, state SKIP, locked kept.
- STALL_TICKS=100, input held low. Expect stall high exactly 100 cycles after the last rise, state IDLE, locked=0.
- AVE_LOG2=2, revolution periods 160,160,200,200 after the first discarded one. Expect rev_period 40,80,130,180.
- With macro defined: a 2-cycle glitch is ignored (no tooth_fall). Without the macro, the same glitch produces a tooth_fall.

Source files
------------

// File: rtl/motor_enc_decoder.sv
// Scan-motor read-head decoder: zero-tooth search, tooth tracking, stall and averaged revolution period.
// Define MOTOR_ENC_FILTER_EN to add a FILT_LEN-cycle glitch filter on the synchronised input.
module motor_enc_decoder #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TEETH       = 44,
  parameter int unsigned VZERO_OFS   = 8,
  parameter int unsigned FEED_FIRST  = 1,
  parameter int unsigned FEED_LAST   = 42,
  parameter int unsigned REGION_END  = 40,
  parameter int unsigned ZR_SHIFT    = 1,
  parameter int unsigned STALL_TICKS = 3125000,
  parameter int unsigned AVE_LOG2    = 2
`ifdef MOTOR_ENC_FILTER_EN
  , parameter int unsigned FILT_LEN  = 4
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             motor_enable,
  input  logic             pulse_sig,
  output logic             real_zero,
  output logic             virtual_zero,
  output logic             tooth_fall,
  output logic             locked,
  output logic             tooth_err,
  output logic             stall,
  output logic             region_done,
  output logic             feed_valid,
  output logic [7:0]       step_idx,
  output logic [CNT_W-1:0] tooth_sub,
  output logic [CNT_W-1:0] tooth_period,
  output logic [CNT_W-1:0] rev_period,
  output logic             rev_valid
);

  localparam int unsigned DEPTH = 1 << AVE_LOG2;
  localparam int unsigned SUM_W = CNT_W + AVE_LOG2;
  localparam logic [7:0] LAST8   = 8'(TEETH - 1);
  localparam logic [7:0] VZ8     = 8'(VZERO_OFS);
  localparam logic [7:0] FF8     = 8'(FEED_FIRST);
  localparam logic [7:0] FL8     = 8'(FEED_LAST);
  localparam logic [7:0] REGION8 = 8'(REGION_END);
  localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_TICKS);
  localparam logic [CNT_W-1:0] STALL_M1  = CNT_W'(STALL_TICKS - 1);

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    PRE1  = 5'b00010,
    HUNT  = 5'b00100,
    SKIP  = 5'b01000,
    TRACK = 5'b10000
  } state_t;

  state_t state;
  logic s1, s2, q, q_d, rise, fall, fall_q, zero_hit, stall_set, vz_evt, rz_evt, push_d;
  logic [CNT_W-1:0] high_cnt, low_cnt, stall_tmr, rev_cnt;
  logic [CNT_W:0]   zr_thr;
  logic [7:0]       track_cnt, track_nxt, step_nxt;
  logic [CNT_W-1:0] hist [DEPTH];
  logic [SUM_W-1:0] sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      q_d <= 1'b0;
    end else begin
      s1  <= pulse_sig;
      s2  <= s1;
      q_d <= q;
    end
  end

`ifdef MOTOR_ENC_FILTER_EN
  localparam int unsigned FW = $clog2(FILT_LEN + 1);
  logic [FW-1:0] filt_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= 1'b0;
      filt_cnt <= '0;
    end else if (s2 == q) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
      q        <= s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end
`else
  assign q = s2;
`endif

  assign rise   = q & ~q_d;
  assign fall   = ~q & q_d;
  assign zr_thr = {1'b0, low_cnt} + {1'b0, (low_cnt >> ZR_SHIFT)};
  assign zero_hit  = q && ({1'b0, high_cnt} > zr_thr);
  // Stall asserts on the cycle the timer reaches STALL_TICKS and pre-empts any fall in that cycle.
  assign stall_set = motor_enable && !rise && (stall_tmr >= STALL_M1);
  assign fall_q    = fall && !stall_set;
  assign feed_valid = (state == TRACK) && (track_cnt >= FF8) && (track_cnt <= FL8);

  always_comb begin
    track_nxt = track_cnt + 8'd1;
    vz_evt    = (state == TRACK) && fall_q && (track_nxt == VZ8);
    step_nxt  = vz_evt ? 8'd0 : step_idx + 8'd1;
    rz_evt    = motor_enable && !stall_set && zero_hit && ((state == HUNT) || (state == TRACK));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_cnt <= '0;
      low_cnt  <= '0;
    end else if (fall) begin
      high_cnt <= '0;
      low_cnt  <= '0;
    end else if (q) begin
      if (high_cnt != '1) high_cnt <= high_cnt + 1'b1;
    end else begin
      if (low_cnt != '1) low_cnt <= low_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_tmr <= '0;
      stall     <= 1'b0;
    end else begin
      stall <= stall_set;
      if (!motor_enable || rise)     stall_tmr <= '0;
      else if (stall_tmr != STALL_MAX) stall_tmr <= stall_tmr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      locked       <= 1'b0;
      track_cnt    <= '0;
      step_idx     <= '0;
      tooth_sub    <= '0;
      tooth_period <= '0;
      real_zero    <= 1'b0;
      virtual_zero <= 1'b0;
      tooth_fall   <= 1'b0;
      tooth_err    <= 1'b0;
      region_done  <= 1'b0;
    end else begin
      real_zero    <= 1'b0;
      virtual_zero <= 1'b0;
      tooth_fall   <= 1'b0;
      tooth_err    <= 1'b0;
      region_done  <= 1'b0;
      if (!motor_enable) begin
        state     <= IDLE;
        locked    <= 1'b0;
        track_cnt <= '0;
        step_idx  <= '0;
        tooth_sub <= '0;
      end else begin
        tooth_fall   <= fall_q;
        virtual_zero <= vz_evt;
        real_zero    <= rz_evt;
        if (fall_q) begin
          step_idx    <= step_nxt;
          region_done <= (step_nxt == REGION8);
        end
        if ((state == TRACK) && !stall_set && !zero_hit) begin
          if (fall_q) begin
            tooth_period <= tooth_sub;
            tooth_sub    <= '0;
          end else if (tooth_sub != '1) begin
            tooth_sub <= tooth_sub + 1'b1;
          end
        end else begin
          tooth_sub <= '0;
        end
        if (stall_set) begin
          state     <= IDLE;
          locked    <= 1'b0;
          track_cnt <= '0;
        end else begin
          unique case (state)
            IDLE: if (fall) state <= PRE1;
            PRE1: if (rise) state <= HUNT;
            HUNT: begin
              if (zero_hit) begin
                state  <= SKIP;
                locked <= 1'b1;
              end else if (fall && locked) begin
                tooth_err <= 1'b1;
                locked    <= 1'b0;
              end
            end
            SKIP: begin
              if (fall) begin
                state     <= TRACK;
                track_cnt <= '0;
              end
            end
            TRACK: begin
              if (zero_hit) begin
                tooth_err <= 1'b1;
                state     <= SKIP;
              end else if (fall) begin
                track_cnt <= track_nxt;
                if (track_nxt == LAST8) state <= HUNT;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  // rev_cnt restarts at 1 so the pushed value equals the zero-to-zero distance in clk cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rev_cnt    <= '0;
      sum        <= '0;
      push_d     <= 1'b0;
      rev_period <= '0;
      rev_valid  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) hist[i] <= '0;
    end else if (!motor_enable) begin
      rev_cnt    <= '0;
      sum        <= '0;
      push_d     <= 1'b0;
      rev_period <= '0;
      rev_valid  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) hist[i] <= '0;
    end else begin
      push_d    <= rz_evt && locked;
      rev_valid <= push_d;
      if (push_d) rev_period <= sum[SUM_W-1:AVE_LOG2];
      if (rz_evt) begin
        rev_cnt <= CNT_W'(1);
        if (locked) begin
          sum     <= sum + SUM_W'(rev_cnt) - SUM_W'(hist[DEPTH-1]);
          hist[0] <= rev_cnt;
          for (int unsigned i = DEPTH - 1; i > 0; i--) hist[i] <= hist[i-1];
        end
      end else if (rev_cnt != '1) begin
        rev_cnt <= rev_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_motor_enc_decoder.sv
// Directed bench for motor_enc_decoder: lock, missing/extra tooth, resync, stall, disable, glitch.
module tb_motor_enc_decoder;

  localparam int CW = 16;
`ifdef MOTOR_ENC_FILTER_EN
  localparam int FILT = 4;
  localparam int LAT  = 3 + FILT;
  localparam int GLITCH_FALLS = 0;
`else
  localparam int LAT  = 3;
  localparam int GLITCH_FALLS = 1;
`endif

  logic clk, rst_n, motor_enable, pulse_sig;
  logic real_zero, virtual_zero, tooth_fall, locked, tooth_err, stall, region_done, feed_valid, rev_valid;
  logic [7:0]    step_idx;
  logic [CW-1:0] tooth_sub, tooth_period, rev_period;

  int checks = 0;
  int failures = 0;

  motor_enc_decoder #(
    .CNT_W(CW), .TEETH(8), .VZERO_OFS(2), .FEED_FIRST(1), .FEED_LAST(6),
    .REGION_END(5), .ZR_SHIFT(1), .STALL_TICKS(100), .AVE_LOG2(2)
`ifdef MOTOR_ENC_FILTER_EN
    , .FILT_LEN(FILT)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .motor_enable(motor_enable), .pulse_sig(pulse_sig),
    .real_zero(real_zero), .virtual_zero(virtual_zero), .tooth_fall(tooth_fall),
    .locked(locked), .tooth_err(tooth_err), .stall(stall), .region_done(region_done),
    .feed_valid(feed_valid), .step_idx(step_idx), .tooth_sub(tooth_sub),
    .tooth_period(tooth_period), .rev_period(rev_period), .rev_valid(rev_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_rz = 0, n_vz = 0, n_tf = 0, n_err = 0, n_reg = 0, n_feed = 0, n_rv = 0, n_rzerr = 0;
  int unsigned rq[$];

  always @(negedge clk) begin
    n_rz    += int'(real_zero);
    n_vz    += int'(virtual_zero);
    n_tf    += int'(tooth_fall);
    n_err   += int'(tooth_err);
    n_reg   += int'(region_done);
    n_feed  += int'(feed_valid);
    n_rzerr += int'(real_zero && tooth_err);
    if (rev_valid) begin
      n_rv++;
      rq.push_back(int'(rev_period));
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tooth(input int h, input int l);
    pulse_sig = 1'b1;
    repeat (h) @(negedge clk);
    pulse_sig = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic rev();
    tooth(40, 10);
    repeat (7) tooth(10, 10);
  endtask

  function automatic logic [31:0] rq_at(input int k);
    return (rq.size() > k) ? rq[k] : 32'hFFFF_FFFF;
  endfunction

  int s_rz, s_vz, s_tf, s_err, s_reg, s_feed, s_rv, s_rzerr, stall_n;

  task automatic snap();
    s_rz = n_rz; s_vz = n_vz; s_tf = n_tf; s_err = n_err;
    s_reg = n_reg; s_feed = n_feed; s_rv = n_rv; s_rzerr = n_rzerr;
  endtask

  initial begin
    rst_n = 1'b0; motor_enable = 1'b0; pulse_sig = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_stall", stall, 0);
    check_eq("rst_step", step_idx, 0);
    check_eq("rst_sub", tooth_sub, 0);
    check_eq("rst_tperiod", tooth_period, 0);
    check_eq("rst_rperiod", rev_period, 0);
    check_eq("rst_strobes", {real_zero, virtual_zero, tooth_fall, tooth_err, region_done, feed_valid, rev_valid}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    motor_enable = 1'b1;
    repeat (2) @(negedge clk);

    // Lock and six clean revolutions of 190 cycles each
    snap();
    repeat (3) tooth(10, 10);
    repeat (6) rev();
    check_eq("a_real_zero", n_rz - s_rz, 6);
    check_eq("a_vzero", n_vz - s_vz, 6);
    check_eq("a_err", n_err - s_err, 0);
    check_eq("a_falls", n_tf - s_tf, 51);
    check_eq("a_region", n_reg - s_reg, 7);
    check_eq("a_feed_cycles", n_feed - s_feed, 720);
    check_eq("a_rev_valid", n_rv - s_rv, 5);
    check_eq("a_rev0", rq_at(0), 47);
    check_eq("a_rev1", rq_at(1), 95);
    check_eq("a_rev2", rq_at(2), 142);
    check_eq("a_rev3", rq_at(3), 190);
    check_eq("a_locked", locked, 1);
    check_eq("a_tperiod", tooth_period, 19);
    check_eq("a_step", step_idx, 5);
    check_eq("a_sub_hunt", tooth_sub, 0);

    // Extra tooth while hunting for the zero: error, unlock, relock
    snap();
    pulse_sig = 1'b1;
    repeat (10) @(negedge clk);
    pulse_sig = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clk);
      check_eq($sformatf("b_lat%0d", i), tooth_fall, (i == LAT) ? 1 : 0);
    end
    repeat (10 - LAT) @(negedge clk);
    check_eq("b_err", n_err - s_err, 1);
    check_eq("b_unlocked", locked, 0);
    repeat (2) rev();
    check_eq("b_real_zero", n_rz - s_rz, 2);
    check_eq("b_err_total", n_err - s_err, 1);
    check_eq("b_relocked", locked, 1);
    check_eq("b_rev_valid", n_rv - s_rv, 1);

    // Zero tooth arriving after only four track falls
    snap();
    tooth(40, 10);
    repeat (4) tooth(10, 10);
    pulse_sig = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("c_feed_skip", feed_valid, 0);
    check_eq("c_sub_skip", tooth_sub, 0);
    check_eq("c_locked_kept", locked, 1);
    pulse_sig = 1'b0;
    repeat (10) @(negedge clk);
    repeat (7) tooth(10, 10);
    check_eq("c_rz_err_same", n_rzerr - s_rzerr, 1);
    check_eq("c_err", n_err - s_err, 1);
    check_eq("c_real_zero", n_rz - s_rz, 2);
    check_eq("c_locked", locked, 1);

    // Input stops toggling mid-revolution
    tooth(40, 10);
    repeat (2) tooth(10, 10);
    pulse_sig = 1'b1;
    stall_n = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (i == 10) pulse_sig = 1'b0;
      if (stall) begin
        stall_n = i;
        break;
      end
    end
    check_eq("d_stall_delay", stall_n, 100 + LAT);
    check_eq("d_unlocked", locked, 0);
    check_eq("d_feed", feed_valid, 0);
    check_eq("d_sub", tooth_sub, 0);
    repeat (5) @(negedge clk);
    check_eq("d_stall_level", stall, 1);

    // Recover, then drop motor_enable mid-revolution
    repeat (3) tooth(10, 10);
    rev();
    tooth(40, 10);
    repeat (3) tooth(10, 10);
    check_eq("e_locked_pre", locked, 1);
    check_eq("e_feed_pre", feed_valid, 1);
    check_eq("e_rev_nonzero", rev_period != 0, 1);
    motor_enable = 1'b0;
    @(negedge clk);
    check_eq("e_locked", locked, 0);
    check_eq("e_step", step_idx, 0);
    check_eq("e_sub", tooth_sub, 0);
    check_eq("e_rperiod", rev_period, 0);
    check_eq("e_feed", feed_valid, 0);
    check_eq("e_stall", stall, 0);
    check_eq("e_tperiod_hold", tooth_period, 19);

    // Two-cycle glitch
    repeat (3) @(negedge clk);
    motor_enable = 1'b1;
    repeat (5) @(negedge clk);
    snap();
    pulse_sig = 1'b1;
    repeat (2) @(negedge clk);
    pulse_sig = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("f_glitch_falls", n_tf - s_tf, GLITCH_FALLS);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

endmodule
